led_pwm_fader: RTL and testbench
================================

Name: led_pwm_fader

Overview:
Parametrised multi-channel PWM LED driver. It is the successor to the fixed 3-colour driver that feeds the RGB LED current driver. Each channel runs one of four modes: off, static duty, linear fade-to-target, or breathing triangle. Channels are configured over a valid/ready write port. The block sits between control logic and the RGB LED current-driver PWM inputs, clocked from the on-chip HF oscillator.

Parameters:
- CHANNELS, 3, number of PWM outputs (1..16).
- WIDTH, 8, duty/counter resolution in bits; PWM period is 2^WIDTH clocks.
- FADE_DIV, 4, number of PWM periods per fade step (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- cfg_valid  in  1  configuration write request.
- cfg_ready  out  1  block can accept a write.
- cfg_chan  in  $clog2(CHANNELS) (min 1)  target channel index.
- cfg_mode  in  2  mode (led_pwm_pkg::mode_e).
- cfg_duty  in  WIDTH  static duty / fade target / breathe peak.
- pwm_out  out  CHANNELS  registered PWM outputs.
- fade_done  out  CHANNELS  one-cycle pulse when a FADE channel reaches its target.

Behaviour:
- Reset: clk only; synchronous, active-low rst_n.
  - While rst_n=0 on a clk edge: pwm_out=0, fade_done=0, cfg_ready=0.
  - Also cleared: all duty/target/shadow regs=0, all modes=OFF, directions=up, counters=0.
  - cfg_ready goes to 1 on the first clk edge with rst_n=1.
  - Reset mid-fade aborts the fade; no fade_done pulse.
- Shared period counter `cnt`, WIDTH bits, increments every clk and wraps 2^WIDTH-1 -> 0. `period_end` = (cnt == 2^WIDTH-1).
- Fade prescaler counts `period_end` pulses 0..FADE_DIV-1. `fade_tick` asserts in the same cycle as the period_end that wraps it.
- Config handshake:
  - A write is accepted when cfg_valid && cfg_ready.
  - cfg_ready is 1 in every non-reset cycle.
  - An accepted write with cfg_chan >= CHANNELS is acknowledged and discarded.
  - Accepted fields land in the channel's mode/target regs one cycle later (t+1).
- Per-channel modes:
  - OFF (2'b00): shadow duty = 0.
  - STATIC (2'b01): shadow duty = target immediately at t+1.
  - FADE (2'b10): on each fade_tick, shadow moves 1 LSB toward target.
    - When shadow becomes equal to target, fade_done[i] pulses for exactly one cycle, then the shadow holds.
    - A write whose target equals the current shadow pulses fade_done on the next fade_tick.
  - BREATHE (2'b11): on each fade_tick, shadow steps ±1 between 0 and target (the peak), reversing direction at each end.
    - Peak 0 holds at 0.
    - A write resets direction to up and does not reset the shadow. If shadow > new peak, it steps down until it is inside the range.
- Glitch-free update: active duty <= shadow only on period_end. A new duty therefore takes effect at the next period start.
- Output: pwm_out[i] is registered as (cnt < active_duty[i]), giving one clk latency from cnt.
  - Duty 0 gives constant low.
  - Duty 2^WIDTH-1 gives high for 2^WIDTH-1 of 2^WIDTH cycles.
  - No arithmetic overflow is possible: steps are saturating by construction.
- Simultaneous events:
  - A write and a fade_tick on the same channel in the same cycle: the write wins and the tick is skipped for that channel.
  - Other channels step normally.

Optional Feature:
- Macro PWM_GAMMA_EN.
- When defined: the comparison uses gamma-corrected duty g = (active_duty*active_duty) >> WIDTH. The square is computed in a 2*WIDTH-bit product, and the result is registered at the period_end load. Output timing is unchanged.
- When undefined: linear duty is used, and no multiplier is instantiated.

Decomposition:
- led_pwm_pkg holds:
  - typedef enum logic [1:0] mode_e {MODE_OFF, MODE_STATIC, MODE_FADE, MODE_BREATHE};
  - the direction typedef.
- One sub-module, led_pwm_channel, instantiated CHANNELS times via generate. It receives cnt, period_end, fade_tick and its decoded write strobe, and holds shadow/active/target/mode/direction and its output flop.
- The top level keeps the period counter, the prescaler and the write decode.

Test Plan:
(WIDTH=8, FADE_DIV=2, CHANNELS=3 unless stated)
- Reset then STATIC duty 64 on ch0 -> from the next period, pwm_out[0] high for exactly 64 of every 256 clks; ch1/ch2 stay 0; cfg_ready=1 from the first post-reset cycle.
- FADE ch1 from 0 to target 5 -> shadow increments every 512 clks; fade_done[1] pulses once, one cycle, at the 5th fade_tick; duty then holds at 5.
- BREATHE ch2 peak 3 -> active duty sequence 1,2,3,2,1,0,1... changing every 2 periods; no pulse runt at any period boundary.
- Write STATIC 200 mid-period with cnt=100 -> the current period keeps the old duty; the new duty applies from cnt=0. Write to cfg_chan=3 -> acknowledged, no channel changes.
- Write to ch1 coincident with fade_tick while ch0 fades -> ch1 takes the new config with no step; ch0 steps normally. Assert rst_n=0 mid-fade -> all outputs 0 next edge; no fade_done.
- With PWM_GAMMA_EN, STATIC 128 -> high 64 clks/period; STATIC 255 -> high 254 clks/period.

Source files
------------

// File: rtl/led_pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM LED fader.
package led_pwm_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_STATIC  = 2'b01,
        MODE_FADE    = 2'b10,
        MODE_BREATHE = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Index width that never collapses to zero bits for a count of one.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One PWM channel: mode/target/shadow/active duty and its registered output.
// Optional gamma correction of the loaded duty when PWM_GAMMA_EN is defined.
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_cnt,
    input  logic             i_period_end,
    input  logic             i_fade_tick,
    input  logic             i_wr_stb,
    input  mode_e            i_wr_mode,
    input  logic [WIDTH-1:0] i_wr_duty,
    output logic             o_pwm,
    output logic             o_fade_done
);

    mode_e            r_mode;
    dir_e             r_dir;
    logic [WIDTH-1:0] r_target;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_active;
    logic             r_pend;
    logic             r_pwm;
    logic             r_done;

    logic [WIDTH-1:0] w_shadow_nxt;
    dir_e             w_dir_nxt;
    logic             w_pend_nxt;
    logic             w_done_nxt;
    logic [WIDTH-1:0] w_load_duty;

`ifdef PWM_GAMMA_EN
    logic [2*WIDTH-1:0] w_square;

    assign w_square    = {{WIDTH{1'b0}}, r_shadow} * {{WIDTH{1'b0}}, r_shadow};
    assign w_load_duty = w_square[2*WIDTH-1:WIDTH];
`else
    assign w_load_duty = r_shadow;
`endif

    always_comb begin
        // NOTE: every next-state signal gets a default first; a path that
        // leaves one unassigned would infer a latch.
        w_shadow_nxt = r_shadow;
        w_dir_nxt    = r_dir;
        w_pend_nxt   = r_pend;
        w_done_nxt   = 1'b0;
        case (r_mode)
            MODE_OFF:    w_shadow_nxt = '0;
            MODE_STATIC: w_shadow_nxt = r_target;
            MODE_FADE: begin
                if (i_fade_tick && r_pend) begin
                    if (r_shadow < r_target) begin
                        w_shadow_nxt = r_shadow + 1'b1;
                    end else if (r_shadow > r_target) begin
                        w_shadow_nxt = r_shadow - 1'b1;
                    end
                    if (w_shadow_nxt == r_target) begin
                        w_done_nxt = 1'b1;
                        w_pend_nxt = 1'b0;
                    end
                end
            end
            MODE_BREATHE: begin
                // Above a lowered peak the shadow walks down into range first.
                if (i_fade_tick) begin
                    if (r_target == '0) begin
                        w_shadow_nxt = '0;
                    end else if (r_shadow > r_target) begin
                        w_shadow_nxt = r_shadow - 1'b1;
                    end else if (r_dir == DIR_UP) begin
                        if (r_shadow < r_target) begin
                            w_shadow_nxt = r_shadow + 1'b1;
                        end else begin
                            w_shadow_nxt = r_shadow - 1'b1;
                            w_dir_nxt    = DIR_DOWN;
                        end
                    end else begin
                        if (r_shadow > '0) begin
                            w_shadow_nxt = r_shadow - 1'b1;
                        end else begin
                            w_shadow_nxt = r_shadow + 1'b1;
                            w_dir_nxt    = DIR_UP;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: all channel state is reset, not only the outputs, so a
            // reset mid-fade cannot leave a pending fade_done behind.
            r_mode   <= MODE_OFF;
            r_dir    <= DIR_UP;
            r_target <= '0;
            r_shadow <= '0;
            r_active <= '0;
            r_pend   <= 1'b0;
            r_pwm    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge
            // values, independent of statement order.
            r_pwm <= (i_cnt < r_active);
            if (i_period_end) begin
                r_active <= w_load_duty;
            end
            if (i_wr_stb) begin
                r_mode   <= i_wr_mode;
                r_target <= i_wr_duty;
                r_dir    <= DIR_UP;
                r_pend   <= (i_wr_mode == MODE_FADE);
                r_done   <= 1'b0;
                if (i_wr_mode == MODE_OFF) begin
                    r_shadow <= '0;
                end else if (i_wr_mode == MODE_STATIC) begin
                    r_shadow <= i_wr_duty;
                end
            end else begin
                r_shadow <= w_shadow_nxt;
                r_dir    <= w_dir_nxt;
                r_pend   <= w_pend_nxt;
                r_done   <= w_done_nxt;
            end
        end
    end

    assign o_pwm       = r_pwm;
    assign o_fade_done = r_done;

endmodule

// File: rtl/led_pwm_fader.sv
// Multi-channel PWM LED fader: shared period counter, fade prescaler and
// config write decode. Define PWM_GAMMA_EN for gamma-corrected duty.
module led_pwm_fader
    import led_pwm_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8,
    parameter int FADE_DIV = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                cfg_valid,
    output logic                                cfg_ready,
    input  logic [clog2_min1(CHANNELS)-1:0]     cfg_chan,
    input  mode_e                               cfg_mode,
    input  logic [WIDTH-1:0]                    cfg_duty,
    output logic [CHANNELS-1:0]                 pwm_out,
    output logic [CHANNELS-1:0]                 fade_done
);

    localparam int CHAN_W = clog2_min1(CHANNELS);
    localparam int PRE_W  = clog2_min1(FADE_DIV);

    logic [WIDTH-1:0]    r_cnt;
    logic [PRE_W-1:0]    r_pre;
    logic                r_cfg_ready;

    logic                w_period_end;
    logic                w_fade_tick;
    logic                w_accept;
    logic [CHANNELS-1:0] w_wr_stb;

    assign w_period_end = (r_cnt == {WIDTH{1'b1}});
    assign w_fade_tick  = w_period_end && (r_pre == PRE_W'(FADE_DIV - 1));
    assign w_accept     = cfg_valid && r_cfg_ready;
    assign cfg_ready    = r_cfg_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_pre       <= '0;
            r_cfg_ready <= 1'b0;
        end else begin
            r_cnt       <= r_cnt + 1'b1;
            r_cfg_ready <= 1'b1;
            if (w_period_end) begin
                r_pre <= w_fade_tick ? '0 : r_pre + 1'b1;
            end
        end
    end

    // Out-of-range channel indices match no strobe and are simply dropped.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        assign w_wr_stb[gi] = w_accept && (cfg_chan == CHAN_W'(gi));

        led_pwm_channel #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_cnt        (r_cnt),
            .i_period_end (w_period_end),
            .i_fade_tick  (w_fade_tick),
            .i_wr_stb     (w_wr_stb[gi]),
            .i_wr_mode    (cfg_mode),
            .i_wr_duty    (cfg_duty),
            .o_pwm        (pwm_out[gi]),
            .o_fade_done  (fade_done[gi])
        );
    end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Scoreboard bench for led_pwm_fader: a cycle-indexed reference model queues
// per-period duty and fade_done expectations; a monitor measures and compares.
module tb_led_pwm_fader;
    import led_pwm_pkg::*;

    localparam int CH  = 3;
    localparam int W   = 8;
    localparam int FD  = 2;
    localparam int PER = 1 << W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_chan;
    mode_e         cfg_mode;
    logic [W-1:0]  cfg_duty;
    logic [CH-1:0] pwm_out;
    logic [CH-1:0] fade_done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    led_pwm_fader #(
        .CHANNELS (CH),
        .WIDTH    (W),
        .FADE_DIV (FD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_mode  (cfg_mode),
        .cfg_duty  (cfg_duty),
        .pwm_out   (pwm_out),
        .fade_done (fade_done)
    );

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int            cyc;
        logic [CH-1:0] bits;
    } done_t;

    int    cyc;
    bit    m_ready;
    bit    m_rst_edge;
    int    m_shadow [CH];
    int    m_target [CH];
    mode_e m_mode   [CH];
    bit    m_up     [CH];
    bit    m_pend   [CH];
    int    exp_q    [CH][$];
    done_t done_q   [$];

    function automatic int shown(input int d);
`ifdef PWM_GAMMA_EN
        return (d * d) >> W;
`else
        return d;
`endif
    endfunction

    initial begin
        bit            pe;
        bit            tick;
        logic [CH-1:0] dbits;
        done_t         dn;
        cyc = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_rst_edge = 1'b1;
                m_ready    = 1'b0;
                cyc        = 0;
                for (int c = 0; c < CH; c++) begin
                    m_shadow[c] = 0;
                    m_target[c] = 0;
                    m_mode[c]   = MODE_OFF;
                    m_up[c]     = 1'b1;
                    m_pend[c]   = 1'b0;
                    exp_q[c].delete();
                end
                done_q.delete();
            end else begin
                m_rst_edge = 1'b0;
                if (cyc == 0) for (int c = 0; c < CH; c++) exp_q[c].push_back(0);
                pe   = (cyc % PER) == PER - 1;
                tick = pe && ((cyc / PER) % FD == FD - 1);
                // Duty visible next period is whatever the shadow holds now.
                if (pe) for (int c = 0; c < CH; c++) exp_q[c].push_back(shown(m_shadow[c]));
                dbits = '0;
                for (int c = 0; c < CH; c++) begin
                    if (cfg_valid && m_ready && int'(cfg_chan) == c) begin
                        m_mode[c]   = cfg_mode;
                        m_target[c] = int'(cfg_duty);
                        m_up[c]     = 1'b1;
                        m_pend[c]   = (cfg_mode == MODE_FADE);
                        if (cfg_mode == MODE_OFF) m_shadow[c] = 0;
                        if (cfg_mode == MODE_STATIC) m_shadow[c] = int'(cfg_duty);
                    end else if (tick) begin
                        if (m_mode[c] == MODE_FADE && m_pend[c]) begin
                            if (m_target[c] > m_shadow[c]) m_shadow[c] += 1;
                            else if (m_target[c] < m_shadow[c]) m_shadow[c] -= 1;
                            if (m_shadow[c] == m_target[c]) begin
                                dbits[c]  = 1'b1;
                                m_pend[c] = 1'b0;
                            end
                        end else if (m_mode[c] == MODE_BREATHE) begin
                            if (m_target[c] == 0) m_shadow[c] = 0;
                            else if (m_shadow[c] > m_target[c]) m_shadow[c] -= 1;
                            else begin
                                if (m_up[c] && m_shadow[c] == m_target[c]) m_up[c] = 1'b0;
                                else if (!m_up[c] && m_shadow[c] == 0) m_up[c] = 1'b1;
                                m_shadow[c] += m_up[c] ? 1 : -1;
                            end
                        end
                    end
                end
                if (dbits != '0) begin
                    dn.cyc  = cyc;
                    dn.bits = dbits;
                    done_q.push_back(dn);
                end
                m_ready = 1'b1;
                cyc++;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        int            acc      [CH];
        bit            low_seen [CH];
        bit            gap      [CH];
        int            k;
        int            e;
        logic [CH-1:0] ed;
        done_t         dn;
        for (int c = 0; c < CH; c++) begin
            acc[c] = 0; low_seen[c] = 1'b0; gap[c] = 1'b0;
        end
        forever begin
            @(posedge clk);
            #1;
            if (m_rst_edge) begin
                check("reset outputs", pwm_out == '0 && fade_done == '0 && cfg_ready == 1'b0,
                      {pwm_out, fade_done, cfg_ready}, 0);
                for (int c = 0; c < CH; c++) begin
                    acc[c] = 0; low_seen[c] = 1'b0; gap[c] = 1'b0;
                end
            end else begin
                k = cyc - 1;
                if (k == 0) check("cfg_ready after reset", cfg_ready == 1'b1, cfg_ready, 1);
                for (int c = 0; c < CH; c++) begin
                    if (pwm_out[c]) begin
                        acc[c]++;
                        if (low_seen[c]) gap[c] = 1'b1;
                    end else begin
                        low_seen[c] = 1'b1;
                    end
                end
                ed = '0;
                if (done_q.size() > 0 && done_q[0].cyc == k) begin
                    dn = done_q.pop_front();
                    ed = dn.bits;
                end
                if (ed != '0 || fade_done != '0)
                    check($sformatf("fade_done cyc %0d", k), fade_done == ed, fade_done, ed);
                if (k % PER == PER - 1) begin
                    for (int c = 0; c < CH; c++) begin
                        if (exp_q[c].size() == 0) begin
                            check($sformatf("duty ch%0d period %0d queue", c, k / PER), 1'b0, acc[c], -1);
                        end else begin
                            e = exp_q[c].pop_front();
                            check($sformatf("duty ch%0d period %0d (gap=%0d)", c, k / PER, gap[c]),
                                  acc[c] == e && !gap[c], acc[c], e);
                        end
                        acc[c] = 0; low_seen[c] = 1'b0; gap[c] = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Return at the negedge before the edge whose cycle index is r modulo m.
    task automatic wait_phase(input int m, input int r);
        int guard;
        guard = 0;
        while ((cyc % m) != r && guard < 4 * m) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("phase %0d mod %0d reached", r, m), (cyc % m) == r, cyc % m, r);
    endtask

    task automatic wr(input int ch, input mode_e m, input int d);
        check($sformatf("cfg_ready before write ch%0d", ch), cfg_ready == 1'b1, cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_chan  = ch[1:0];
        cfg_mode  = m;
        cfg_duty  = d[W-1:0];
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : (v > PER - 1) ? PER - 1 : v;
    endfunction

    initial begin
        int    ch;
        int    d;
        int    rs;
        mode_e m;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_chan  = '0;
        cfg_mode  = MODE_OFF;
        cfg_duty  = '0;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        wr(0, MODE_STATIC, 64);
        idle(600);
        wr(1, MODE_FADE, 5);
        idle(PER * FD * 6);
        wr(2, MODE_BREATHE, 3);
        idle(PER * FD * 7);

        wait_phase(PER, 100);
        wr(0, MODE_STATIC, 200);
        wr(3, MODE_STATIC, 77);
        idle(600);

        // Write to ch1 lands on a fade tick while ch0 fades down.
        wr(0, MODE_FADE, 196);
        wait_phase(PER * FD, PER * FD - 1);
        wr(1, MODE_STATIC, 9);
        idle(PER * FD * 5);
        wr(2, MODE_FADE, m_shadow[2]);
        idle(PER * FD * 2);

        repeat (40) begin
            ch = $urandom_range(0, 3);
            m  = mode_e'($urandom_range(0, 3));
            rs = m_shadow[(ch < CH) ? ch : 0];
            if (m == MODE_FADE) d = clamp(rs + int'($urandom_range(0, 8)) - 4);
            else if (m == MODE_BREATHE) d = $urandom_range(0, 6);
            else d = $urandom_range(0, PER - 1);
            wr(ch, m, d);
            idle($urandom_range(0, 600));
        end

        // Reset in the middle of a fade that still has steps to go.
        wr(0, MODE_STATIC, 20);
        idle(5);
        wr(0, MODE_FADE, 24);
        wait_phase(PER * FD, PER * FD - 1);
        idle(PER * FD + 300);
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(2);
        wr(0, MODE_STATIC, 10);
        idle(PER * 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
